// File: rtl/instruction_loader_pkg.sv
// Shared types and helpers for the instruction memory write-side loader.
// Byte lanes are numbered big-endian: lane 0 is the most significant byte.
package instruction_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int INSTR_BYTES = 4;

    function automatic logic [7:0] byte_of(input logic [31:0] word,
                                           input logic [1:0]  k);
        return word[31 - 8*int'(k) -: 8];
    endfunction

endpackage

// File: rtl/instruction_loader_byte_serializer.sv
// Holds one captured word and streams it out as four byte writes,
// most significant byte first, to consecutive addresses.
module word_byte_serializer
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [31:0]       i_word,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [7:0]        o_data,
    output logic              o_last_byte
);

    logic [31:0]       r_word;
    logic [ADDR_W-1:0] r_base;
    logic [1:0]        r_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_data;
    logic [1:0]        w_nidx;

    assign w_nidx = r_idx + 2'd1;

    // Outputs are registered so byte 0 appears the cycle after capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_word <= '0;
            r_base <= '0;
            r_idx  <= '0;
            r_we   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else if (i_load) begin
            r_word <= i_word;
            r_base <= i_addr;
            r_idx  <= 2'd0;
            r_we   <= 1'b1;
            r_addr <= i_addr;
            r_data <= byte_of(i_word, 2'd0);
        end else if (r_we) begin
            if (r_idx == 2'd3) begin
                r_we <= 1'b0;
            end else begin
                r_idx  <= w_nidx;
                r_addr <= r_base + {{(ADDR_W-2){1'b0}}, w_nidx};
                r_data <= byte_of(r_word, w_nidx);
            end
        end
    end

    assign o_we        = r_we;
    assign o_addr      = r_addr;
    assign o_data      = r_data;
    assign o_last_byte = r_we && (r_idx == 2'd3);

endmodule

// File: rtl/instruction_loader.sv
// Loads 32-bit instruction words from a valid/ready stream into the
// byte-wide instruction memory, big-endian, one byte per cycle.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              loadStart,
    input  logic              instrValid,
    input  logic [31:0]       instrWord,
    input  logic              instrLast,
    output logic              instrReady,
    output logic              memWriteEnable,
    output logic [ADDR_W-1:0] memWriteAddr,
    output logic [7:0]        memWriteData,
    output logic              loadBusy,
    output logic              loadDone,
    output logic              loadOverflow,
    output logic [ADDR_W-2:0] wordCount
);

    localparam logic [ADDR_W-2:0] CAP =
        (ADDR_W-1)'((MEM_BYTES - BASE_ADDR) / INSTR_BYTES);
    localparam logic [ADDR_W-2:0] CNT_ONE   = (ADDR_W-1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(INSTR_BYTES);

    state_t            r_state;
    state_t            w_next;
    logic              r_ready;
    logic              r_busy;
    logic              r_done;
    logic              r_ovf;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-2:0] r_count;
    logic              w_cap;
    logic              w_ovf;
    logic              w_start;
    logic              w_word_end;
    logic              w_last_byte;

    always_comb begin
        w_next  = r_state;
        w_cap   = 1'b0;
        w_ovf   = 1'b0;
        w_start = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (loadStart) begin
                    w_start = 1'b1;
                    w_next  = ACCEPT;
                end
            end
            ACCEPT: begin
                if (instrValid && r_ready) begin
                    if (r_count == CAP) begin
                        w_ovf  = 1'b1;
                        w_next = DONE;
                    end else begin
                        w_cap  = 1'b1;
                        w_next = WRITE;
                    end
                end
            end
            WRITE: begin
                if (w_last_byte) begin
                    w_next = r_last ? DONE : ACCEPT;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_word_end = (r_state == WRITE) && w_last_byte;

    // Status outputs are registered from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            r_last  <= 1'b0;
            r_addr  <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == ACCEPT);
            r_busy  <= (w_next != IDLE);
            r_done  <= (w_next == DONE);
            if (w_start) begin
                r_addr  <= ADDR_BASE;
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end
            if (w_cap) begin
                r_last <= instrLast;
            end
            if (w_word_end) begin
                r_addr  <= r_addr + ADDR_STEP;
                r_count <= r_count + CNT_ONE;
            end
        end
    end

    word_byte_serializer #(
        .ADDR_W(ADDR_W)
    ) u_ser (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_cap),
        .i_word     (instrWord),
        .i_addr     (r_addr),
        .o_we       (memWriteEnable),
        .o_addr     (memWriteAddr),
        .o_data     (memWriteData),
        .o_last_byte(w_last_byte)
    );

    assign instrReady   = r_ready;
    assign loadBusy     = r_busy;
    assign loadDone     = r_done;
    assign loadOverflow = r_ovf;
    assign wordCount    = r_count;

endmodule

// File: doc/instruction_loader.md
# instruction_loader

Write-side counterpart of the instruction memory: accepts 32-bit instruction words over a valid/ready stream and writes them into the byte-wide instruction memory array, big-endian, one byte per cycle. The most significant byte lands at the lowest address, so the read side reassembles each word from memory[pc..pc+3]. It sits between the program source (testbench, boot ROM or debug port) and the memory's write port, and runs only while the CPU is held out of fetch.

## Interface
Parameters:
- MEM_BYTES, 64, instruction memory depth in bytes; multiple of 4.
- ADDR_W, 6, byte-address width; equals clog2(MEM_BYTES).
- BASE_ADDR, 0, first byte address written per session; multiple of 4.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- loadStart  in  1  one-cycle pulse that starts a session; honoured only in IDLE.
- instrValid  in  1  instrWord/instrLast valid.
- instrWord  in  32  instruction word.
- instrLast  in  1  final word of the session.
- instrReady  out  1  registered; high only in ACCEPT.
- memWriteEnable  out  1  byte write strobe.
- memWriteAddr  out  ADDR_W  byte address.
- memWriteData  out  8  byte data.
- loadBusy  out  1  high in every state except IDLE.
- loadDone  out  1  one-cycle pulse, high in DONE.
- loadOverflow  out  1  sticky; cleared by the next accepted loadStart.
- wordCount  out  ADDR_W-1  words written this session.

## Operation
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE -> ACCEPT on loadStart. The address register loads BASE_ADDR; wordCount and loadOverflow clear.
- ACCEPT: instrReady=1. A handshake occurs on an edge where instrValid and instrReady are both high.
  - Word, last flag and current address are captured. Next state is WRITE.
  - Exception: if wordCount == (MEM_BYTES-BASE_ADDR)/4, the word is discarded, loadOverflow is set, and next state is DONE.
- WRITE: 4 cycles, memWriteEnable=1.
  - Byte index k=0..3 drives memWriteData=word[31-8k -: 8] and memWriteAddr=addr+k.
  - After k=3: the address advances by 4 and wordCount increments. Next state is DONE if the captured last flag is set, otherwise ACCEPT.
- DONE: loadDone=1 for one cycle, then IDLE.
- Writing exactly to capacity with instrLast on the final word is legal and does not set overflow.
- loadStart outside IDLE is ignored.
- Address arithmetic is modulo 2^ADDR_W. It never wraps in legal use because the capacity check fires first.

## Timing
- Reset values: instrReady=0, memWriteEnable=0, memWriteAddr=0, memWriteData=0, loadBusy=0, loadDone=0, loadOverflow=0, wordCount=0, state=IDLE.
- loadStart at edge N: instrReady=1 from cycle N+1.
- Handshake at edge H: byte 0 is written in cycle H+1 and byte 3 in cycle H+4.
  - instrReady=0 during cycles H+1..H+4.
  - instrReady returns to 1 in cycle H+5. Throughput is 1 word per 5 cycles.
- Last word handshaked at edge H: loadDone=1 in cycle H+5, then IDLE with loadBusy=0 in cycle H+6.
- Overflow handshake at edge H: loadOverflow=1 and loadDone=1 in cycle H+1, with no memory write.
- All outputs are registered; there is no combinational path from any input to any output.
- reset_n assertion mid-WRITE: all outputs go to reset values immediately. The partial word is abandoned; bytes already written stay in memory.

## Structure
- Package instruction_loader_pkg holds:
  - state enum (IDLE, ACCEPT, WRITE, DONE);
  - INSTR_BYTES=4;
  - byte-lane extraction function byte_of(word, k).
- Natural sub-module: word_byte_serializer.
  - Holds the captured word, base address and 2-bit byte counter.
  - Produces the write strobe/addr/data and a lastByte flag.
  - The top-level keeps the FSM, address and count registers, and the overflow/done logic.

## Test plan
- Single word 0x8B030022 with instrLast, BASE_ADDR=0 -> writes 8B@0, 03@1, 00@2, 22@3 on 4 consecutive cycles; loadDone pulses 1 cycle later; wordCount=1.
- Words 0xF84083E1, 0xF84103E2 (last on 2nd), instrValid held high -> ready gap of 4 cycles between handshakes; bytes at addr 0..7 in order; wordCount=2.
- 16 words with last on 16th, MEM_BYTES=64 -> final write at addr 63, loadOverflow=0, loadDone once.
- 17th word offered without last after 16 -> no write, loadOverflow=1 and loadDone in the next cycle; overflow stays high until the next loadStart.
- reset_n low during byte index 2 of word 0xCB0400A6 -> outputs reset asynchronously; after release, state is IDLE and loadStart restarts at BASE_ADDR.
- loadStart pulsed during WRITE, and instrValid held low in ACCEPT for 10 cycles -> no restart, no writes while idle-waiting, memWriteEnable=0.
